// File: rtl/fifo_ctrl.sv
// fifo_ctrl: parametrised synchronous FIFO with fill level, almost-full /
// almost-empty thresholds, guarded accesses, sticky overflow / underflow
// flags and a selectable first-word fall-through or registered read port.
module fifo_ctrl #(
    parameter int C_FIFO_WIDTH   = 32,
    parameter int C_FIFO_DEPTH_X = 2,
    parameter int C_AF_LEVEL     = (2 ** C_FIFO_DEPTH_X) - 1,
    parameter int C_AE_LEVEL     = 1,
    parameter int C_FWFT         = 1
) (
    input  logic                      clk_i,
    input  logic                      reset_i,
    input  logic                      clk_en_i,
    input  logic                      flush_i,
    input  logic                      wr_i,
    input  logic [C_FIFO_WIDTH-1:0]   din_i,
    input  logic                      rd_i,
    output logic [C_FIFO_WIDTH-1:0]   dout_o,
    output logic                      dout_valid_o,
    output logic                      empty_o,
    output logic                      full_o,
    output logic                      almost_empty_o,
    output logic                      almost_full_o,
    output logic [C_FIFO_DEPTH_X:0]   level_o,
    output logic                      overflow_o,
    output logic                      underflow_o
);

    localparam int C_FIFO_DEPTH = 2 ** C_FIFO_DEPTH_X;
    localparam int C_PTR_W      = C_FIFO_DEPTH_X + 1;

    // Reject illegal configurations while elaborating.
    if (C_FIFO_WIDTH < 1) begin : g_bad_width
        $error("fifo_ctrl: C_FIFO_WIDTH must be >= 1");
    end
    if (C_FIFO_DEPTH_X < 1) begin : g_bad_depth
        $error("fifo_ctrl: C_FIFO_DEPTH_X must be >= 1");
    end
    if (C_AF_LEVEL < 1 || C_AF_LEVEL > C_FIFO_DEPTH) begin : g_bad_af
        $error("fifo_ctrl: C_AF_LEVEL must be in 1..C_FIFO_DEPTH");
    end
    if (C_AE_LEVEL < 0 || C_AE_LEVEL > C_FIFO_DEPTH - 1) begin : g_bad_ae
        $error("fifo_ctrl: C_AE_LEVEL must be in 0..C_FIFO_DEPTH-1");
    end
    if (C_FWFT != 0 && C_FWFT != 1) begin : g_bad_fwft
        $error("fifo_ctrl: C_FWFT must be 0 or 1");
    end

    logic [C_FIFO_WIDTH-1:0]   r_mem [C_FIFO_DEPTH];
    logic [C_PTR_W-1:0]        r_wr_ptr;
    logic [C_PTR_W-1:0]        r_rd_ptr;
    logic                      r_overflow;
    logic                      r_underflow;

    logic [C_PTR_W-1:0]        w_level;
    logic                      w_empty;
    logic                      w_full;
    logic                      w_rd_acc;
    logic                      w_wr_acc;
    logic                      w_update;
    logic [C_PTR_W-2:0]        w_wr_idx;
    logic [C_PTR_W-2:0]        w_rd_idx;

    // Status is derived only from registered pointers; the wrap bit makes
    // full and empty distinguishable when the index bits are equal.
    assign w_level  = r_wr_ptr - r_rd_ptr;
    assign w_empty  = (w_level == '0);
    assign w_full   = (w_level == C_PTR_W'(C_FIFO_DEPTH));
    assign w_rd_acc = rd_i & ~w_empty;
    // A write into a full FIFO is safe when a pop frees the slot in the same cycle.
    assign w_wr_acc = wr_i & (~w_full | rd_i);
    assign w_update = clk_en_i & ~flush_i;
    assign w_wr_idx = r_wr_ptr[C_PTR_W-2:0];
    assign w_rd_idx = r_rd_ptr[C_PTR_W-2:0];

    assign empty_o        = w_empty;
    assign full_o         = w_full;
    assign level_o        = w_level;
    assign almost_full_o  = (w_level >= C_PTR_W'(C_AF_LEVEL));
    assign almost_empty_o = (w_level <= C_PTR_W'(C_AE_LEVEL));
    assign overflow_o     = r_overflow;
    assign underflow_o    = r_underflow;

    // Pointer advance on accepted accesses; flush rewinds both to zero.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples pre-edge values regardless of block ordering.
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else if (clk_en_i) begin
            if (flush_i) begin
                r_wr_ptr <= '0;
                r_rd_ptr <= '0;
            end else begin
                if (w_wr_acc) r_wr_ptr <= r_wr_ptr + 1'b1;
                if (w_rd_acc) r_rd_ptr <= r_rd_ptr + 1'b1;
            end
        end
    end

    // Sticky error flags, cleared only by flush or reset.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else if (clk_en_i) begin
            if (flush_i) begin
                r_overflow  <= 1'b0;
                r_underflow <= 1'b0;
            end else begin
                if (wr_i & ~w_wr_acc) r_overflow  <= 1'b1;
                if (rd_i & w_empty)   r_underflow <= 1'b1;
            end
        end
    end

    // Storage array write port.
    // NOTE: the array has no reset; clearing it would turn a RAM into flops
    // and the pointers alone already define which entries are meaningful.
    always_ff @(posedge clk_i) begin
        if (w_update && w_wr_acc) r_mem[w_wr_idx] <= din_i;
    end

    if (C_FWFT == 1) begin : g_fwft
        // Head word is presented combinationally; rd_i acknowledges it.
        assign dout_o       = r_mem[w_rd_idx];
        assign dout_valid_o = ~w_empty;
    end else begin : g_reg
        logic [C_FIFO_WIDTH-1:0] r_dout;
        logic                    r_dout_valid;

        // Registered read port: load the head on a pop, pulse valid for one cycle.
        always_ff @(posedge clk_i or posedge reset_i) begin
            if (reset_i) begin
                r_dout       <= '0;
                r_dout_valid <= 1'b0;
            end else if (clk_en_i) begin
                if (flush_i) begin
                    r_dout_valid <= 1'b0;
                end else begin
                    r_dout_valid <= w_rd_acc;
                    if (w_rd_acc) r_dout <= r_mem[w_rd_idx];
                end
            end
        end

        assign dout_o       = r_dout;
        assign dout_valid_o = r_dout_valid;
    end

endmodule

// File: tb/tb_fifo_ctrl.sv
// tb_fifo_ctrl: drives a fall-through and a registered-output fifo_ctrl with
// identical stimulus and compares both against a queue-based reference model.
module tb_fifo_ctrl;

    localparam int W  = 8;
    localparam int DX = 2;
    localparam int D  = 4;
    localparam int AF = 3;
    localparam int AE = 1;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         clk_en = 1'b0;
    logic         flush = 1'b0;
    logic         wr = 1'b0;
    logic         rd = 1'b0;
    logic [W-1:0] din = '0;

    logic [W-1:0] dout_f, dout_r;
    logic         valid_f, valid_r;
    logic         empty_f, empty_r, full_f, full_r;
    logic         ae_f, ae_r, af_f, af_r;
    logic [DX:0]  level_f, level_r;
    logic         ovf_f, ovf_r, unf_f, unf_r;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    logic [W-1:0] q[$];
    bit           m_ovf, m_unf, m_valid;
    logic [W-1:0] m_dout;

    always #5 clk = ~clk;

    fifo_ctrl #(.C_FIFO_WIDTH(W), .C_FIFO_DEPTH_X(DX), .C_AF_LEVEL(AF),
                .C_AE_LEVEL(AE), .C_FWFT(1)) u_fwft (
        .clk_i(clk), .reset_i(reset), .clk_en_i(clk_en), .flush_i(flush),
        .wr_i(wr), .din_i(din), .rd_i(rd),
        .dout_o(dout_f), .dout_valid_o(valid_f),
        .empty_o(empty_f), .full_o(full_f),
        .almost_empty_o(ae_f), .almost_full_o(af_f),
        .level_o(level_f), .overflow_o(ovf_f), .underflow_o(unf_f));

    fifo_ctrl #(.C_FIFO_WIDTH(W), .C_FIFO_DEPTH_X(DX), .C_AF_LEVEL(AF),
                .C_AE_LEVEL(AE), .C_FWFT(0)) u_reg (
        .clk_i(clk), .reset_i(reset), .clk_en_i(clk_en), .flush_i(flush),
        .wr_i(wr), .din_i(din), .rd_i(rd),
        .dout_o(dout_r), .dout_valid_o(valid_r),
        .empty_o(empty_r), .full_o(full_r),
        .almost_empty_o(ae_r), .almost_full_o(af_r),
        .level_o(level_r), .overflow_o(ovf_r), .underflow_o(unf_r));

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_ovf   = 1'b0;
        m_unf   = 1'b0;
        m_valid = 1'b0;
        m_dout  = '0;
    endtask

    // One clock of the FIFO's behaviour expressed as queue operations.
    task automatic model_step(input bit en, input bit fl, input bit w,
                              input bit r, input logic [W-1:0] d);
        int n;
        bit rd_ok;
        bit wr_ok;
        if (!en) return;
        if (fl) begin
            q.delete();
            m_ovf   = 1'b0;
            m_unf   = 1'b0;
            m_valid = 1'b0;
            return;
        end
        n     = q.size();
        rd_ok = r && (n > 0);
        wr_ok = w && ((n < D) || r);
        if (r && n == 0) m_unf = 1'b1;
        if (w && !wr_ok) m_ovf = 1'b1;
        m_valid = rd_ok;
        if (rd_ok) m_dout = q.pop_front();
        if (wr_ok) q.push_back(d);
    endtask

    task automatic compare_all();
        int n;
        n = q.size();
        check("f_level", 32'(level_f), n);
        check("f_empty", 32'(empty_f), 32'(n == 0));
        check("f_full",  32'(full_f),  32'(n == D));
        check("f_ae",    32'(ae_f),    32'(n <= AE));
        check("f_af",    32'(af_f),    32'(n >= AF));
        check("f_ovf",   32'(ovf_f),   32'(m_ovf));
        check("f_unf",   32'(unf_f),   32'(m_unf));
        check("f_valid", 32'(valid_f), 32'(n > 0));
        if (n > 0) check("f_dout", 32'(dout_f), 32'(q[0]));
        check("r_level", 32'(level_r), n);
        check("r_empty", 32'(empty_r), 32'(n == 0));
        check("r_full",  32'(full_r),  32'(n == D));
        check("r_ae",    32'(ae_r),    32'(n <= AE));
        check("r_af",    32'(af_r),    32'(n >= AF));
        check("r_ovf",   32'(ovf_r),   32'(m_ovf));
        check("r_unf",   32'(unf_r),   32'(m_unf));
        check("r_valid", 32'(valid_r), 32'(m_valid));
        check("r_dout",  32'(dout_r),  32'(m_dout));
    endtask

    // Inputs change just after the falling edge; outputs are compared at the next falling edge.
    task automatic cycle(input bit en, input bit fl, input bit w, input bit r,
                         input logic [W-1:0] d);
        clk_en = en;
        flush  = fl;
        wr     = w;
        rd     = r;
        din    = d;
        @(posedge clk);
        model_step(en, fl, w, r, d);
        @(negedge clk);
        compare_all();
    endtask

    initial begin
        logic [W-1:0] fill [4];
        fill[0] = 8'h11; fill[1] = 8'h22; fill[2] = 8'h33; fill[3] = 8'h44;

        // Reset state
        model_reset();
        @(negedge clk);
        @(negedge clk);
        compare_all();
        reset  = 1'b0;
        clk_en = 1'b1;

        // Fill and drain
        for (int i = 0; i < 4; i++) cycle(1, 0, 1, 0, fill[i]);
        check("tp1_full_f", 32'(full_f), 32'd1);
        for (int i = 0; i < 4; i++) cycle(1, 0, 0, 1, 8'h00);
        check("tp1_empty_r", 32'(empty_r), 32'd1);

        // Write when full, then drain
        for (int i = 0; i < 4; i++) cycle(1, 0, 1, 0, fill[i]);
        cycle(1, 0, 1, 0, 8'h55);
        check("tp2_ovf_f", 32'(ovf_f), 32'd1);
        check("tp2_level_r", 32'(level_r), 32'd4);
        for (int i = 0; i < 4; i++) cycle(1, 0, 0, 1, 8'h00);

        // Read when empty, then flush
        cycle(1, 0, 0, 1, 8'h00);
        check("tp3_unf_r", 32'(unf_r), 32'd1);
        cycle(1, 1, 1, 1, 8'h99);
        check("tp3_unf_clr_f", 32'(unf_f), 32'd0);
        check("tp3_ovf_clr_r", 32'(ovf_r), 32'd0);

        // Full, then simultaneous read and write
        for (int i = 0; i < 4; i++) cycle(1, 0, 1, 0, fill[i]);
        cycle(1, 0, 1, 1, 8'h66);
        check("tp4_level_f", 32'(level_f), 32'd4);
        check("tp4_ovf_f", 32'(ovf_f), 32'd0);
        for (int i = 0; i < 5; i++) cycle(1, 0, 0, 1, 8'h00);
        cycle(1, 1, 0, 0, 8'h00);

        // Wrap: single-word round trips, then fill
        for (int i = 0; i < 10; i++) begin
            cycle(1, 0, 1, 0, 8'(i));
            cycle(1, 0, 0, 1, 8'h00);
        end
        for (int i = 0; i < 4; i++) cycle(1, 0, 1, 0, 8'hC0 + 8'(i));
        check("tp5_full_f", 32'(full_f), 32'd1);
        check("tp5_noempty_r", 32'(empty_r), 32'd0);
        cycle(1, 1, 0, 0, 8'h00);

        // Clock enable low freezes everything, including flush
        cycle(1, 0, 1, 0, 8'hE1);
        cycle(0, 0, 1, 0, 8'hE2);
        cycle(0, 1, 0, 1, 8'hE3);
        cycle(0, 0, 0, 1, 8'hE4);
        check("tp6_en_level_f", 32'(level_f), 32'd1);
        cycle(1, 0, 0, 1, 8'h00);

        // Asynchronous reset mid-burst at level 2
        cycle(1, 0, 1, 0, 8'hA1);
        cycle(1, 0, 1, 0, 8'hA2);
        #2 reset = 1'b1;
        #1;
        model_reset();
        compare_all();
        check("tp6_rst_level_f", 32'(level_f), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        cycle(1, 0, 1, 0, 8'hB1);
        cycle(1, 0, 0, 1, 8'h00);

        // Random traffic
        for (int i = 0; i < 800; i++) begin
            cycle(($urandom_range(0, 9) != 0), ($urandom_range(0, 39) == 0),
                  ($urandom_range(0, 99) < 55), ($urandom_range(0, 99) < 50),
                  8'($urandom));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
